emu_ckpt_scan_ctrl: RTL
=======================

// Module: emu_ckpt_scan_ctrl
// PURPOSE
//  Host-side scan checkpoint controller driving the EMU_DUT scan ports (emu_ff_*/emu_ram_*).
//  SAVE: pauses DUT clocks, shifts out the FF chain then the RAM chain into an internal checkpoint buffer.
//  LOAD: shifts the buffer back in, then resumes. Buffer is host read/writable while idle.
//  Buffer layout: words [0..FF_WORDS-1] FF chain, [FF_WORDS..FF_WORDS+MEM_WORDS-1] RAM chain.
// PARAMETERS
//  DW        64  scan word width (emu_*_di/do)
//  FF_WORDS  4   FF chain length in words (CHAIN_FF_WORDS)
//  MEM_WORDS 16  RAM chain length in words (CHAIN_MEM_WORDS)
//  RAM_LEAD  2   cycles of emu_ram_se before first valid emu_ram_do on save
//  RAM_TAIL  1   extra emu_ram_se cycles after last emu_ram_di on load
//  AW        $clog2(FF_WORDS+MEM_WORDS)  buffer address width (derived)
// PORTS
//  emu_host_clk    in   1   host clock; all logic on rising edge
//  emu_host_rst_n  in   1   async active-low reset
//  cmd_valid       in   1   start request
//  cmd_load        in   1   0=SAVE, 1=LOAD; sampled with cmd_valid
//  cmd_ready       out  1   =!busy; command accepted on cmd_valid&&cmd_ready
//  busy            out  1   operation in progress
//  done            out  1   1-cycle pulse when operation completes
//  ckpt_valid      out  1   set by completed SAVE, cleared by reset
//  buf_en          in   1   host buffer access (ignored while busy)
//  buf_we          in   1   host write when buf_en
//  buf_addr        in   AW  host word address
//  buf_wdata       in   DW  host write data
//  buf_rdata       out  DW  host read data, 1-cycle latency
//  emu_pause       out  1   gates DUT ff/ram clocks (OR'ed with scan enables externally)
//  emu_ff_se       out  1   FF chain scan enable
//  emu_ff_di       out  DW  FF scan in: ff_do on SAVE (loopback), buffer word on LOAD
//  emu_ff_do       in   DW  FF scan out
//  emu_ram_se      out  1   RAM chain scan enable
//  emu_ram_sd      out  1   RAM scan direction: 0=dump, 1=load
//  emu_ram_di      out  DW  RAM scan in (LOAD)
//  emu_ram_do      in   DW  RAM scan out (SAVE)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cmd_ready=1. Reset mid-op drops pause/se at once; chain and buffer contents undefined.
//  States: IDLE, PAUSE, FF_SAVE, RAM_LEAD, RAM_SAVE, FF_LOAD, RAM_LOAD, RAM_TAIL, RESUME.
//  IDLE: accept cmd -> PAUSE (busy=1, emu_pause=1 from next cycle).
//  PAUSE (1 cyc): LOAD prefetches buffer word 0; -> FF_SAVE or FF_LOAD.
//  FF_SAVE (FF_WORDS cyc): ff_se=1; cycle k writes buf[k]=emu_ff_do; emu_ff_di=emu_ff_do combinationally (non-destructive rotate).
//  RAM_LEAD (RAM_LEAD cyc): ram_se=1, ram_sd=0, nothing captured.
//  RAM_SAVE (MEM_WORDS cyc): ram_se=1, ram_sd=0; cycle k writes buf[FF_WORDS+k]=emu_ram_do; -> RESUME.
//  FF_LOAD (FF_WORDS cyc): ff_se=1, emu_ff_di=buf[k]; word k+1 prefetched during cycle k.
//  RAM_LOAD (MEM_WORDS cyc): ram_se=1, ram_sd=1, emu_ram_di=buf[FF_WORDS+k]; no gap after FF_LOAD.
//  RAM_TAIL (RAM_TAIL cyc): ram_se=1, ram_sd=1, emu_ram_di holds last word; -> RESUME.
//  RESUME (1 cyc): all se=0, emu_pause=1. Next cycle: emu_pause=0, busy=0, done=1; SAVE sets ckpt_valid.
//  se never overlaps: ff_se and ram_se not both 1 in any cycle. Every scan cycle is registered-output driven.
//  Totals: SAVE busy = 2+FF_WORDS+RAM_LEAD+MEM_WORDS cyc; LOAD = 2+FF_WORDS+MEM_WORDS+RAM_TAIL.
//  Counters wrap-free: word counter resets to 0 at each state entry, compares to len-1.
//  cmd_valid while busy: ignored (no queueing). buf_en while busy: ignored, buf_rdata holds.
//  LOAD allowed with ckpt_valid=0 (host-written buffer); ckpt_valid unchanged by LOAD.
//  Host write and controller access never coincide (host blocked while busy).
// STRUCTURE
//  Shared package emu_scan_pkg: state encoding localparams, CMD_SAVE/CMD_LOAD constants.
//  Sub-module emu_ckpt_buf: 1R1W sync RAM, DW x (FF_WORDS+MEM_WORDS), 1-cyc read; port muxed host/controller on busy.
//  Top: FSM + word counter + phase counter + output regs.
// TESTING (FF_WORDS=3, MEM_WORDS=8, bench DUT model = rotating FF chain + RAM chain with 2-cyc lead)
//  SAVE after writing mem[j]=j*0x1111 -> buf[3..10] match RAM chain model, done after 15 cyc, ckpt_valid=1.
//  SAVE twice back-to-back -> identical buffer contents (FF dump non-destructive), FF state unchanged after resume.
//  Host writes buf[i]=0xA5A5_0000+i, LOAD -> emu_ff_di sequence 0xA5A50000..02 then ram_di ..03..0A, tail holds ..0A.
//  SAVE, scramble DUT, LOAD -> DUT mem/rdata equal pre-SAVE values; emu_pause low only after done.
//  cmd_valid and buf_en(we) during busy -> ignored; buffer word unchanged, no second done.
//  Assert emu_host_rst_n low mid RAM_SAVE -> same cycle pause=se=0, busy=0, ckpt_valid=0; new SAVE completes normally.

Source files
------------

// File: rtl/emu_scan_pkg.sv
// Shared definitions for the emulator scan checkpoint controller:
// FSM state encoding and host command encoding.
package emu_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PAUSE    = 4'd1,
    ST_FF_SAVE  = 4'd2,
    ST_RAM_LEAD = 4'd3,
    ST_RAM_SAVE = 4'd4,
    ST_FF_LOAD  = 4'd5,
    ST_RAM_LOAD = 4'd6,
    ST_RAM_TAIL = 4'd7,
    ST_RESUME   = 4'd8
  } state_e;

  localparam logic CMD_SAVE = 1'b0;
  localparam logic CMD_LOAD = 1'b1;

endpackage

// File: rtl/emu_ckpt_buf.sv
// Checkpoint buffer: one write port, one read port, registered read data.
// The read register only updates on a read, so its value holds otherwise.
module emu_ckpt_buf
  import emu_scan_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 20,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/emu_ckpt_scan_ctrl.sv
// Scan checkpoint controller: pauses the emulated DUT and moves its FF and RAM
// scan chains to/from an internal buffer that the host can access while idle.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE      | waiting for a command; host owns the buffer
//   PAUSE     | DUT clocks stopped; LOAD fetches buffer word 0
//   FF_SAVE   | FF chain rotated (looped back) while each word is captured
//   RAM_LEAD  | RAM chain dump started, output not valid yet
//   RAM_SAVE  | RAM chain words captured into the buffer
//   FF_LOAD   | buffer words shifted into the FF chain
//   RAM_LOAD  | buffer words shifted into the RAM chain
//   RAM_TAIL  | RAM scan held on the last word to let the load settle
//   RESUME    | scan enables dropped; DUT still paused for one cycle
module emu_ckpt_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int DW        = 64,
  parameter int FF_WORDS  = 4,
  parameter int MEM_WORDS = 16,
  parameter int RAM_LEAD  = 2,
  parameter int RAM_TAIL  = 1,
  parameter int AW        = $clog2(FF_WORDS + MEM_WORDS)
) (
  input  logic          emu_host_clk,
  input  logic          emu_host_rst_n,
  input  logic          cmd_valid,
  input  logic          cmd_load,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic          ckpt_valid,
  input  logic          buf_en,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_addr,
  input  logic [DW-1:0] buf_wdata,
  output logic [DW-1:0] buf_rdata,
  output logic          emu_pause,
  output logic          emu_ff_se,
  output logic [DW-1:0] emu_ff_di,
  input  logic [DW-1:0] emu_ff_do,
  output logic          emu_ram_se,
  output logic          emu_ram_sd,
  output logic [DW-1:0] emu_ram_di,
  input  logic [DW-1:0] emu_ram_do
);

  localparam int DEPTH = FF_WORDS + MEM_WORDS;
  localparam int CW    = $clog2(DEPTH + RAM_LEAD + RAM_TAIL + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;
  logic          op_load_q, op_load_d;
  logic          busy_q, busy_d, done_q, done_d, ckpt_valid_q, ckpt_valid_d;
  logic          pause_q, pause_d, ff_se_q, ff_se_d;
  logic          ram_se_q, ram_se_d, ram_sd_q, ram_sd_d;
  logic          host_rd_q, host_rd_d;
  logic [DW-1:0] rdata_hold_q, rdata_hold_d;

  logic          ctrl_we, ctrl_re, host_en;
  logic [AW-1:0] ctrl_waddr, ctrl_raddr;
  logic [DW-1:0] ctrl_wdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always_comb begin
    case (state_q)
      ST_FF_SAVE, ST_FF_LOAD:   cnt_last = (cnt_q == CW'(FF_WORDS - 1));
      ST_RAM_LEAD:              cnt_last = (cnt_q == CW'(RAM_LEAD - 1));
      ST_RAM_SAVE, ST_RAM_LOAD: cnt_last = (cnt_q == CW'(MEM_WORDS - 1));
      ST_RAM_TAIL:              cnt_last = (cnt_q == CW'(RAM_TAIL - 1));
      default:                  cnt_last = 1'b1;
    endcase
  end

  // Every transition happens on cnt_last, so the counter restarts at 0 on entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_last ? '0 : cnt_q + CW'(1);
    op_load_d  = op_load_q;
    ctrl_we    = 1'b0;
    ctrl_re    = 1'b0;
    ctrl_waddr = AW'(cnt_q);
    ctrl_wdata = emu_ff_do;
    ctrl_raddr = AW'(cnt_q) + AW'(1);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_PAUSE;
          op_load_d = (cmd_load == CMD_LOAD);
        end
      end
      ST_PAUSE: begin
        ctrl_re    = op_load_q;
        ctrl_raddr = '0;
        state_d    = op_load_q ? ST_FF_LOAD : ST_FF_SAVE;
      end
      ST_FF_SAVE: begin
        ctrl_we = 1'b1;
        if (cnt_last) state_d = ST_RAM_LEAD;
      end
      ST_RAM_LEAD: begin
        if (cnt_last) state_d = ST_RAM_SAVE;
      end
      ST_RAM_SAVE: begin
        ctrl_we    = 1'b1;
        ctrl_waddr = AW'(FF_WORDS) + AW'(cnt_q);
        ctrl_wdata = emu_ram_do;
        if (cnt_last) state_d = ST_RESUME;
      end
      ST_FF_LOAD: begin
        ctrl_re = 1'b1;
        if (cnt_last) state_d = ST_RAM_LOAD;
      end
      ST_RAM_LOAD: begin
        // no fetch on the last word: the read register then holds it through the tail
        ctrl_re    = !cnt_last;
        ctrl_raddr = AW'(FF_WORDS) + AW'(cnt_q) + AW'(1);
        if (cnt_last) state_d = ST_RAM_TAIL;
      end
      ST_RAM_TAIL: begin
        if (cnt_last) state_d = ST_RESUME;
      end
      ST_RESUME: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    pause_d      = busy_d;
    ff_se_d      = state_d inside {ST_FF_SAVE, ST_FF_LOAD};
    ram_se_d     = state_d inside {ST_RAM_LEAD, ST_RAM_SAVE, ST_RAM_LOAD, ST_RAM_TAIL};
    ram_sd_d     = state_d inside {ST_RAM_LOAD, ST_RAM_TAIL};
    done_d       = (state_q == ST_RESUME);
    ckpt_valid_d = ckpt_valid_q | (done_d & (op_load_q == CMD_SAVE));
  end

  assign host_en      = buf_en & !busy_q;
  assign host_rd_d    = host_en & !buf_we;
  assign rdata_hold_d = buf_rdata;

  assign mem_we    = busy_q ? ctrl_we    : (host_en & buf_we);
  assign mem_waddr = busy_q ? ctrl_waddr : buf_addr;
  assign mem_wdata = busy_q ? ctrl_wdata : buf_wdata;
  assign mem_re    = busy_q ? ctrl_re    : host_rd_d;
  assign mem_raddr = busy_q ? ctrl_raddr : buf_addr;

  emu_ckpt_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (emu_host_clk),
    .rst_n (emu_host_rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge emu_host_clk or negedge emu_host_rst_n) begin
    if (!emu_host_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_load_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ckpt_valid_q <= 1'b0;
      pause_q      <= 1'b0;
      ff_se_q      <= 1'b0;
      ram_se_q     <= 1'b0;
      ram_sd_q     <= 1'b0;
      host_rd_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_load_q    <= op_load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ckpt_valid_q <= ckpt_valid_d;
      pause_q      <= pause_d;
      ff_se_q      <= ff_se_d;
      ram_se_q     <= ram_se_d;
      ram_sd_q     <= ram_sd_d;
      host_rd_q    <= host_rd_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign cmd_ready  = !busy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ckpt_valid = ckpt_valid_q;
  assign emu_pause  = pause_q;
  assign emu_ff_se  = ff_se_q;
  assign emu_ram_se = ram_se_q;
  assign emu_ram_sd = ram_sd_q;
  assign buf_rdata  = host_rd_q ? mem_rdata : rdata_hold_q;
  // SAVE loops the chain back on itself so the dump leaves FF state intact.
  assign emu_ff_di  = ff_se_q ? (op_load_q ? mem_rdata : emu_ff_do) : '0;
  assign emu_ram_di = ram_sd_q ? mem_rdata : '0;

endmodule
